dot_accum: RTL
==============

DOT_ACCUM -- requirements
Module: dot_accum

Interface
REQ-001 SHALL have parameter DATA_W, default 8, activation and weight width in bits.
REQ-002 SHALL have parameter ACC_W, default 32, accumulator, bias and result width in bits.
REQ-003 SHALL have parameter CNT_W, default 16, beat-counter width in bits.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  beat offered.
REQ-007 SHALL have port in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-008 SHALL have port in_act  input  DATA_W  signed activation.
REQ-009 SHALL have port in_wgt  input  DATA_W  signed weight.
REQ-010 SHALL have port in_last  input  1  final beat of the current dot product.
REQ-011 SHALL have port zp_in  input  DATA_W  signed input zero-point, quasi-static.
REQ-012 SHALL have port bias  input  ACC_W  signed bias, sampled on the first accepted beat of each group.
REQ-013 SHALL have port out_valid  output  1  result held.
REQ-014 SHALL have port out_ready  input  1  result consumed when out_valid && out_ready.
REQ-015 SHALL have port out_acc  output  ACC_W  signed result, feeds the requantiser in_acc.
REQ-016 SHALL have port out_len  output  CNT_W  number of beats in the emitted group.
REQ-017 SHALL have port busy  output  1  high while a group is open, from its first accepted beat until its last beat is accepted.

Function
REQ-018 SHALL compute per-beat product p = (in_act - zp_in) * in_wgt as a (2*DATA_W+1)-bit signed value, then sign-extend it to ACC_W.
REQ-019 SHALL accumulate modulo 2^ACC_W (two's-complement wrap, no saturation); saturation is the downstream stage's job.
REQ-020 SHALL run an FSM with states IDLE (no open group) and ACCUM (group open); output holding is tracked separately by out_valid.
REQ-021 On an accepted beat in IDLE with in_last=0: acc <= bias + p, cnt <= 1, go to ACCUM.
REQ-022 On an accepted beat in ACCUM with in_last=0: acc <= acc + p, cnt <= cnt + 1, stay in ACCUM.
REQ-023 On an accepted beat with in_last=1: out_acc <= base + p, where base = bias in IDLE and acc in ACCUM; out_len <= cnt + 1 (1 in IDLE); out_valid <= 1; go to IDLE. A single-beat group is legal.
REQ-024 in_ready SHALL be !out_valid || out_ready, combinational, and independent of in_valid and in_last.
REQ-025 Latency: the result SHALL be visible on out_acc with out_valid=1 one cycle after its last beat is accepted.
REQ-026 Throughput: one beat per cycle SHALL be sustained with out_ready=1, including back-to-back groups with no bubble between a last beat and the next first beat.
REQ-027 out_valid SHALL clear on a handshake unless a new last beat is accepted in the same cycle, in which case out_valid stays 1 and out_acc and out_len load the new result.
REQ-028 While out_valid=1 and out_ready=0, out_acc and out_len SHALL hold stable and no beat SHALL be accepted.
REQ-029 If cnt would exceed 2^CNT_W-1, cnt SHALL saturate at all-ones; acc continues to accumulate.
REQ-030 busy SHALL equal (state == ACCUM).
REQ-031 in_act, in_wgt, in_last and bias SHALL be ignored on any cycle with no handshake.

Reset
REQ-032 With rst=1 at a clock edge, the block SHALL force state=IDLE, acc=0, cnt=0, out_valid=0, out_acc=0 and out_len=0.
REQ-033 Reset mid-group SHALL discard the partial sum, and the first beat accepted after reset SHALL start a new group.
REQ-034 in_ready SHALL be 1 in the first cycle after reset.

Verification
REQ-035 zp_in=0, bias=100, beats (2,3),(4,-5),(-1,7 last), out_ready=1 -> one cycle later out_acc=79, out_len=3, out_valid=1 for one cycle.
REQ-036 zp_in=-128, bias=0, single beat act=127, wgt=127, last -> out_acc=32385, out_len=1.
REQ-037 Two groups back to back with out_ready=0 at the second last beat -> in_ready=0, first result held stable; after out_ready=1, the second group completes with no beat lost.
REQ-038 ACC_W=32, bias=32'h7FFFFFFF, beat (1,1 last), zp_in=0 -> out_acc=32'h80000000 (wrap).
REQ-039 rst=1 asserted after two beats of an open group -> out_valid=0, busy=0; a new group (5,5 last) with bias=0 -> out_acc=25, out_len=1.
REQ-040 Continuous random beats with random group lengths and random out_ready -> every out_acc matches a reference model sum and no handshake rule is violated.

Source files
------------

// File: rtl/dot_accum_if.sv
// Stream interface for dot_accum: beat input channel and result output channel.
interface dot_accum_if #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 32,
   parameter int CNT_W  = 16
);
   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] in_act;
   logic signed [DATA_W-1:0] in_wgt;
   logic                     in_last;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [ACC_W-1:0]  out_acc;
   logic [CNT_W-1:0]         out_len;

   // Producer of beats and consumer of results.
   modport master (
      output in_valid, in_act, in_wgt, in_last, out_ready,
      input  in_ready, out_valid, out_acc, out_len
   );

   // The accumulator itself.
   modport slave (
      input  in_valid, in_act, in_wgt, in_last, out_ready,
      output in_ready, out_valid, out_acc, out_len
   );
endinterface

// File: rtl/dot_accum.sv
// Zero-point corrected dot-product accumulator. Beats stream in, one signed
// (act - zp) * wgt product per beat; the group sum (plus bias) is emitted one
// cycle after the last beat, held until consumed.
module dot_accum #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 32,
   parameter int CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   dot_accum_if.slave               bus,
   input  logic signed [DATA_W-1:0] zp_in,
   input  logic signed [ACC_W-1:0]  bias,
   output logic                     busy
);
   localparam int PW = 2*DATA_W + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t                  state, state_nxt;
   logic signed [DATA_W:0]  diff;
   logic signed [PW-1:0]    diff_x, wgt_x, prod;
   logic signed [ACC_W-1:0] p_ext, base, sum, acc;
   logic [CNT_W-1:0]        cnt, cnt_nxt;
   logic                    fire;
   logic                    out_valid_q;
   logic signed [ACC_W-1:0] out_acc_q;
   logic [CNT_W-1:0]        out_len_q;

   // A held result blocks new beats only while the consumer stalls.
   assign bus.in_ready  = !out_valid_q || bus.out_ready;
   assign fire          = bus.in_valid && bus.in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_acc   = out_acc_q;
   assign bus.out_len   = out_len_q;
   assign busy          = (state == ACCUM);

   // One extra bit keeps act - zp exact; the product is exact in 2*DATA_W+1 bits.
   assign diff   = $signed({bus.in_act[DATA_W-1], bus.in_act}) - $signed({zp_in[DATA_W-1], zp_in});
   assign diff_x = PW'(diff);
   assign wgt_x  = PW'(bus.in_wgt);
   assign prod   = diff_x * wgt_x;
   assign p_ext  = ACC_W'(prod);

   // Bias seeds the first beat of a group; later beats build on the running sum.
   assign base    = (state == ACCUM) ? acc : bias;
   assign sum     = base + p_ext;
   assign cnt_nxt = (state == IDLE) ? CNT_ONE : ((cnt == CNT_MAX) ? cnt : cnt + CNT_ONE);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state: a group opens on a non-last beat and closes on its last beat.
   always_comb begin
      state_nxt = state;
      if (fire) state_nxt = bus.in_last ? IDLE : ACCUM;
   end

   // Running sum, beat count and the held result.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc         <= '0;
         cnt         <= '0;
         out_valid_q <= 1'b0;
         out_acc_q   <= '0;
         out_len_q   <= '0;
      end else begin
         if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
         if (fire) begin
            if (bus.in_last) begin
               out_acc_q   <= sum;
               out_len_q   <= cnt_nxt;
               out_valid_q <= 1'b1;
            end else begin
               acc <= sum;
               cnt <= cnt_nxt;
            end
         end
      end
   end
endmodule
